// File: rtl/vecmac_sched_pkg.sv
// Shared types and constants for the vecmac_scheduler slice: FSM states, the
// in-flight tag record and the MAC opcode driven to the VECMAC unit.
package vecmac_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_t;

  localparam logic [2:0] MAC_OP_MAC = 3'b001;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } sched_tag_t;

  function automatic logic [TAG_ID_W-1:0] rr_next(input logic [TAG_ID_W-1:0] cur,
                                                  input int num_req);
    return (int'(cur) == num_req - 1) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/vecmac_sched_fifo.sv
// Synchronous FIFO with occupancy count; backs both the tag queue and the
// response queue of vecmac_scheduler. DEPTH must be a power of two >= 2.
module vecmac_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  // A full FIFO may still take a push when the same cycle frees a slot.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vecmac_scheduler.sv
// Round-robin job scheduler in front of a shared VECMAC unit, with in-order
// tag tracking and a credited response queue. Define VECMAC_SCHED_PERF_EN to
// add the perf_busy_cycles / perf_jobs counters.
module vecmac_scheduler
  import vecmac_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int VECTOR_WIDTH = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int TAG_DEPTH    = 8,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ-1:0]                        req_last,
  input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_a,
  input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_b,
  input  logic [NUM_REQ*VECTOR_WIDTH-1:0]           req_mask,
  output logic                                      mac_enable,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        mac_vector_a,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        mac_vector_b,
  output logic [VECTOR_WIDTH-1:0]                   mac_mask_a,
  output logic [VECTOR_WIDTH-1:0]                   mac_mask_b,
  output logic                                      mac_accumulate,
  output logic [2:0]                                mac_operation,
  input  logic [ACCUM_WIDTH-1:0]                    mac_result,
  input  logic                                      mac_valid_out,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                rsp_id,
  output logic [ACCUM_WIDTH-1:0]                    rsp_data
`ifdef VECMAC_SCHED_PERF_EN
  ,
  output logic [31:0]                               perf_busy_cycles,
  output logic [31:0]                               perf_jobs
`endif
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int LANE_W = VECTOR_WIDTH * DATA_WIDTH;
  localparam int TAG_CW = $clog2(TAG_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
  localparam int RSP_W  = ID_W + ACCUM_WIDTH;
  localparam logic [TAG_CW-1:0] TAG_LIMIT = TAG_CW'(TAG_DEPTH);

  sched_state_t        state;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     cand;
  logic                pick_found;
  logic                first_beat;

  logic                owner_valid;
  logic                owner_last;
  logic                credit_beat;
  logic                credit_last;
  logic                beat_ok;
  logic                hs;
  logic [LANE_W-1:0]   sel_a;
  logic [LANE_W-1:0]   sel_b;
  logic [VECTOR_WIDTH-1:0] sel_mask;

  sched_tag_t          tag_in;
  sched_tag_t          tag_head;
  logic                tag_push;
  logic                tag_pop;
  logic                tag_empty;
  logic                tag_full;
  logic [TAG_CW-1:0]   tag_count;
  logic [TAG_CW-1:0]   inflight_last;

  logic [RSP_W-1:0]    rsp_in;
  logic [RSP_W-1:0]    rsp_head;
  logic                rsp_push;
  logic                rsp_pop;
  logic                rsp_empty;
  logic                rsp_full;
  logic [RSP_CW-1:0]   rsp_count;

  logic                err_underflow;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign sel_a       = req_vec_a[owner*LANE_W +: LANE_W];
  assign sel_b       = req_vec_b[owner*LANE_W +: LANE_W];
  assign sel_mask    = req_mask[owner*VECTOR_WIDTH +: VECTOR_WIDTH];

  // A last beat also reserves a response slot, so a job result can never be dropped.
  assign credit_beat = (tag_count < TAG_LIMIT);
  assign credit_last = ((int'(rsp_count) + int'(inflight_last)) < RSP_DEPTH);
  assign beat_ok     = credit_beat && (!owner_last || credit_last);
  assign hs          = (state == ST_BURST) && owner_valid && beat_ok;

  always_comb begin
    req_ready = '0;
    if (state == ST_BURST && beat_ok) begin
      req_ready[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      first_beat     <= 1'b1;
      mac_enable     <= 1'b0;
      mac_accumulate <= 1'b0;
      mac_vector_a   <= '0;
      mac_vector_b   <= '0;
      mac_mask_a     <= '0;
      mac_mask_b     <= '0;
      mac_operation  <= '0;
    end else begin
      mac_enable <= hs;
      if (hs) begin
        mac_vector_a   <= sel_a;
        mac_vector_b   <= sel_b;
        mac_mask_a     <= sel_mask;
        mac_mask_b     <= sel_mask;
        mac_operation  <= MAC_OP_MAC;
        mac_accumulate <= !first_beat;
      end
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            owner      <= pick_idx;
            first_beat <= 1'b1;
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (hs) begin
            first_beat <= 1'b0;
            if (owner_last) begin
              state  <= ST_IDLE;
              rr_ptr <= ID_W'(rr_next(TAG_ID_W'(owner), NUM_REQ));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tags are queued at handshake time so the credit check sees every accepted beat.
  assign tag_in.id   = TAG_ID_W'(owner);
  assign tag_in.last = owner_last;
  assign tag_push    = hs;
  assign tag_pop     = mac_valid_out && !tag_empty;

  vecmac_sched_fifo #(
    .WIDTH ($bits(sched_tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  assign rsp_push = tag_pop && tag_head.last;
  assign rsp_in   = {tag_head.id[ID_W-1:0], mac_result};
  assign rsp_pop  = rsp_valid && rsp_ready;

  vecmac_sched_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .empty     (rsp_empty),
    .full      (rsp_full),
    .count     (rsp_count)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_id    = rsp_valid ? rsp_head[RSP_W-1 -: ID_W] : '0;
  assign rsp_data  = rsp_valid ? rsp_head[ACCUM_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_last <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({tag_push && owner_last, rsp_push})
        2'b10:   inflight_last <= inflight_last + 1'b1;
        2'b01:   inflight_last <= inflight_last - 1'b1;
        default: inflight_last <= inflight_last;
      endcase
      if (mac_valid_out && tag_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef VECMAC_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_jobs        <= '0;
    end else begin
      if (state == ST_BURST && perf_busy_cycles != '1) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (rsp_pop && perf_jobs != '1) begin
        perf_jobs <= perf_jobs + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vecmac_scheduler.sv
// Directed testbench for vecmac_scheduler with a behavioural VECMAC model
// whose result return can be held back to keep beats in flight.
module tb_vecmac_scheduler;

  localparam int NR = 4;
  localparam int VW = 16;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LW = VW * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_last = '0;
  logic [NR*LW-1:0]  req_vec_a = '0;
  logic [NR*LW-1:0]  req_vec_b = '0;
  logic [NR*VW-1:0]  req_mask = '0;
  logic              mac_enable;
  logic [LW-1:0]     mac_vector_a;
  logic [LW-1:0]     mac_vector_b;
  logic [VW-1:0]     mac_mask_a;
  logic [VW-1:0]     mac_mask_b;
  logic              mac_accumulate;
  logic [2:0]        mac_operation;
  logic [AW-1:0]     mac_result = '0;
  logic              mac_valid_out = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [AW-1:0]     rsp_data;

  logic              mac_hold = 1'b0;
  int unsigned       model_acc = 0;
  int unsigned       res_q[$];
  logic              acc_log[$];
  int                grant_log[$];
  int                rsp_id_log[$];
  int                rsp_data_log[$];
  int                en_count = 0;
  int                mv_count = 0;
  int                cmp_cnt = 0;
  int                fail_cnt = 0;

  always #5 clk = ~clk;

  vecmac_scheduler #(
    .NUM_REQ(NR), .VECTOR_WIDTH(VW), .DATA_WIDTH(DW),
    .ACCUM_WIDTH(AW), .TAG_DEPTH(8), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_vec_a(req_vec_a), .req_vec_b(req_vec_b), .req_mask(req_mask),
    .mac_enable(mac_enable), .mac_vector_a(mac_vector_a), .mac_vector_b(mac_vector_b),
    .mac_mask_a(mac_mask_a), .mac_mask_b(mac_mask_b), .mac_accumulate(mac_accumulate),
    .mac_operation(mac_operation), .mac_result(mac_result), .mac_valid_out(mac_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // VECMAC model: masked dot product with accumulate, results returned in order.
  always @(posedge clk) begin
    int unsigned sum;
    if (mac_enable) begin
      sum = 0;
      for (int e = 0; e < VW; e++) begin
        if (mac_mask_a[e] && mac_mask_b[e]) begin
          sum += int'(mac_vector_a[e*DW +: DW]) * int'(mac_vector_b[e*DW +: DW]);
        end
      end
      model_acc = mac_accumulate ? model_acc + sum : sum;
      res_q.push_back(model_acc);
      acc_log.push_back(mac_accumulate);
    end
    mac_valid_out <= 1'b0;
    if (!mac_hold && res_q.size() > 0) begin
      mac_result    <= res_q.pop_front();
      mac_valid_out <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && req_ready[r]) grant_log.push_back(r);
      end
      if (mac_enable) en_count++;
      if (mac_valid_out) mv_count++;
      if (rsp_valid && rsp_ready) begin
        rsp_id_log.push_back(int'(rsp_id));
        rsp_data_log.push_back(int'(rsp_data));
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_vec_a = '0; req_vec_b = '0; req_mask = '0;
    rsp_ready = 1'b0; mac_hold = 1'b0;
    res_q.delete(); acc_log.delete(); grant_log.delete();
    rsp_id_log.delete(); rsp_data_log.delete();
    repeat (2) step();
    rst_n = 1'b1;
    en_count = 0; mv_count = 0;
  endtask

  task automatic apply_stimulus(input int r, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] m, input logic last);
    req_vec_a[r*LW +: LW] = {VW{av}};
    req_vec_b[r*LW +: LW] = {VW{bv}};
    req_mask[r*VW +: VW]  = m;
    req_last[r]  = last;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_handshake(input int r, input string tag);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (req_ready[r]) break;
      n++;
    end
    check_output({tag, "_handshake"}, 64'(n < 100), 64'd1);
    step();
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic send_beat(input int r, input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] m, input logic last, input string tag);
    apply_stimulus(r, av, bv, m, last);
    wait_handshake(r, tag);
  endtask

  task automatic pop_rsp(input int eid, input int edata, input string tag);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    check_output({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check_output({tag, "_id"}, 64'(rsp_id), 64'(eid));
    check_output({tag, "_data"}, 64'(rsp_data), 64'(edata));
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    #1 rst_n = 1'b0;
    #2;
    $display("[TB] reset state");
    check_output("rst_req_ready", 64'(req_ready), 64'd0);
    check_output("rst_mac_enable", 64'(mac_enable), 64'd0);
    check_output("rst_mac_accumulate", 64'(mac_accumulate), 64'd0);
    check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("rst_mac_vector_a", 64'(|mac_vector_a), 64'd0);
    check_output("rst_mac_operation", 64'(mac_operation), 64'd0);
    check_output("rst_rsp_data", 64'(rsp_data), 64'd0);
    do_reset();

    $display("[TB] three-beat job from requester 0");
    send_beat(0, 8'd1, 8'd2, 16'hFFFF, 1'b0, "t1_b0");
    send_beat(0, 8'd1, 8'd2, 16'hFFFF, 1'b0, "t1_b1");
    send_beat(0, 8'd1, 8'd2, 16'hFFFF, 1'b1, "t1_b2");
    check_output("t1_mac_enable", 64'(mac_enable), 64'd1);
    check_output("t1_mac_operation", 64'(mac_operation), 64'd1);
    check_output("t1_mac_mask_b", 64'(mac_mask_b), 64'hFFFF);
    check_output("t1_mac_vector_b", mac_vector_b[63:0], 64'h0202020202020202);
    pop_rsp(0, 96, "t1_rsp");
    repeat (8) step();
    check_output("t1_acc_count", 64'(acc_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("t1_acc_%0d", i), 64'(acc_log[i]), (i == 0) ? 64'd0 : 64'd1);
    end
    check_output("t1_enable_pulses", 64'(en_count), 64'd3);
    check_output("t1_mac_results", 64'(mv_count), 64'd3);
    check_output("t1_rsp_count", 64'(rsp_id_log.size()), 64'd1);
    check_output("t1_rsp_drained", 64'(rsp_valid), 64'd0);

    $display("[TB] round-robin fairness");
    do_reset();
    rsp_ready = 1'b1;
    for (int r = 0; r < NR; r++) apply_stimulus(r, 8'(r + 1), 8'd1, 16'hFFFF, 1'b1);
    n = 0;
    while (grant_log.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    step();
    req_valid = '0;
    req_last  = '0;
    n = 0;
    while (rsp_id_log.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("t2_grant_count", 64'(grant_log.size()), 64'd5);
    check_output("t2_rsp_count", 64'(rsp_id_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("t2_grant_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
      check_output($sformatf("t2_rsp_id_%0d", i), 64'(rsp_id_log[i]), 64'(exp_order[i]));
      check_output($sformatf("t2_rsp_data_%0d", i), 64'(rsp_data_log[i]),
                   64'(16 * (exp_order[i] + 1)));
    end

    $display("[TB] response credit back-pressure");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_beat(0, 8'(k + 1), 8'd1, 16'hFFFF, 1'b1, $sformatf("t3_job%0d", k));
    end
    apply_stimulus(0, 8'd5, 8'd1, 16'hFFFF, 1'b1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (req_ready[0]) seen = 1'b1;
    end
    check_output("t3_fifth_stalled", 64'(seen), 64'd0);
    check_output("t3_rsp_pending", 64'(rsp_valid), 64'd1);
    pop_rsp(0, 16, "t3_rsp0");
    wait_handshake(0, "t3_job4");
    for (int k = 1; k < 5; k++) begin
      pop_rsp(0, 16 * (k + 1), $sformatf("t3_rsp%0d", k));
    end

    $display("[TB] partial mask from requester 1");
    do_reset();
    send_beat(1, 8'd3, 8'd3, 16'h00FF, 1'b1, "t4_b0");
    check_output("t4_mac_mask_a", 64'(mac_mask_a), 64'h00FF);
    check_output("t4_mac_accumulate", 64'(mac_accumulate), 64'd0);
    pop_rsp(1, 72, "t4_rsp");

    $display("[TB] reset with beats in flight");
    do_reset();
    mac_hold = 1'b1;
    send_beat(0, 8'd1, 8'd1, 16'hFFFF, 1'b0, "t5_b0");
    send_beat(0, 8'd1, 8'd1, 16'hFFFF, 1'b1, "t5_b1");
    repeat (3) step();
    check_output("t5_tags_in_flight", 64'(dut.tag_count), 64'd2);
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_tag_count", 64'(dut.tag_count), 64'd0);
    check_output("t5_rst_rsp_count", 64'(dut.rsp_count), 64'd0);
    check_output("t5_rst_mac_vector_a", 64'(|mac_vector_a), 64'd0);
    check_output("t5_rst_mac_mask_a", 64'(mac_mask_a), 64'd0);
    check_output("t5_rst_mac_operation", 64'(mac_operation), 64'd0);
    check_output("t5_rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    mac_hold = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_output("t5_no_stale_rsp", 64'(seen), 64'd0);
    check_output("t5_err_underflow", 64'(dut.err_underflow), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
